fractal_sync_mp_cam_ctr: RTL



---
 rtl/fractal_sync_mp_cam_ctr.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/fractal_sync_mp_cam_ctr.sv
// Multi-port counting CAM for a fractal sync node: each line tracks one barrier
// signature, counts arrivals against a target and frees itself on completion.
module fractal_sync_mp_cam_ctr #(
  parameter int unsigned SIG_WIDTH = 8,
  parameter int unsigned N_PORTS   = 2,
  parameter int unsigned N_LINES   = 2,
  parameter int unsigned CNT_WIDTH = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           req_i       [N_PORTS],
  input  logic [SIG_WIDTH-1:0]           sig_i       [N_PORTS],
  input  logic [CNT_WIDTH-1:0]           tgt_i       [N_PORTS],
  output logic                           gnt_o       [N_PORTS],
  output logic                           done_o      [N_PORTS],
  output logic                           full_o,
  output logic [$clog2(N_LINES+1)-1:0]   occupancy_o,
  output logic                           mismatch_o
);

  localparam int unsigned LW  = (N_LINES > 1) ? $clog2(N_LINES) : 1;
  localparam int unsigned PW  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int unsigned CW1 = CNT_WIDTH + 1;
  localparam int unsigned OW  = $clog2(N_LINES + 1);

  if (N_LINES < 1) begin : g_bad_lines
    $fatal(1, "fractal_sync_mp_cam_ctr: N_LINES must be >= 1");
  end
  if (N_PORTS < 1) begin : g_bad_ports
    $fatal(1, "fractal_sync_mp_cam_ctr: N_PORTS must be >= 1");
  end

  // Line state
  logic                 valid_q [N_LINES];
  logic [SIG_WIDTH-1:0] sig_q   [N_LINES];
  logic [CNT_WIDTH-1:0] cnt_q   [N_LINES];
  logic [CNT_WIDTH-1:0] tgt_q   [N_LINES];
  logic                 done_q  [N_PORTS];
  logic                 mismatch_q;

  // Per-port decode
  logic [CNT_WIDTH-1:0] tgt_eff    [N_PORTS];
  logic                 hit_any    [N_PORTS];
  logic [LW-1:0]        hit_line   [N_PORTS];
  logic                 miss       [N_PORTS];
  logic [PW-1:0]        leader     [N_PORTS];
  logic                 alloc_ok   [N_PORTS];
  logic [LW-1:0]        alloc_line [N_PORTS];
  logic                 gnt        [N_PORTS];
  logic [LW-1:0]        map_line   [N_PORTS];

  // Per-line update
  logic                 taken      [N_LINES];
  logic [PW-1:0]        alloc_ldr  [N_LINES];
  logic [CW1-1:0]       n_arr      [N_LINES];
  logic [CW1-1:0]       new_cnt    [N_LINES];
  logic [CNT_WIDTH-1:0] line_tgt   [N_LINES];
  logic                 complete   [N_LINES];
  logic                 mismatch_set;
  logic                 found;
  logic [OW-1:0]        occ;

  always_comb begin
    found        = 1'b0;
    mismatch_set = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      tgt_eff[i]    = (tgt_i[i] == '0) ? CNT_WIDTH'(1) : tgt_i[i];
      hit_any[i]    = 1'b0;
      hit_line[i]   = '0;
      alloc_ok[i]   = 1'b0;
      alloc_line[i] = '0;
      for (int j = 0; j < N_LINES; j++) begin
        if (req_i[i] && valid_q[j] && (sig_q[j] == sig_i[i])) begin
          hit_any[i]  = 1'b1;
          hit_line[i] = LW'(j);
        end
      end
      miss[i] = req_i[i] && !hit_any[i];
    end

    // Leader = lowest-index missing port carrying the same signature.
    for (int i = 0; i < N_PORTS; i++) begin
      leader[i] = PW'(i);
      found     = 1'b0;
      for (int k = 0; k < N_PORTS; k++) begin
        if (k < i && !found && miss[k] && (sig_i[k] == sig_i[i])) begin
          leader[i] = PW'(k);
          found     = 1'b1;
        end
      end
    end

    for (int j = 0; j < N_LINES; j++) begin
      taken[j]     = 1'b0;
      alloc_ldr[j] = '0;
    end
    // Groups claim the lowest free line in leader-port order.
    for (int i = 0; i < N_PORTS; i++) begin
      if (miss[i] && (leader[i] == PW'(i))) begin
        found = 1'b0;
        for (int j = 0; j < N_LINES; j++) begin
          if (!found && !valid_q[j] && !taken[j]) begin
            found         = 1'b1;
            taken[j]      = 1'b1;
            alloc_ldr[j]  = PW'(i);
            alloc_ok[i]   = 1'b1;
            alloc_line[i] = LW'(j);
          end
        end
      end
    end

    for (int i = 0; i < N_PORTS; i++) begin
      gnt[i]      = hit_any[i] || (miss[i] && alloc_ok[leader[i]]);
      map_line[i] = hit_any[i] ? hit_line[i] : alloc_line[leader[i]];
      if (hit_any[i] && (tgt_eff[i] != tgt_q[hit_line[i]])) mismatch_set = 1'b1;
      if (miss[i] && (tgt_eff[i] != tgt_eff[leader[i]]))    mismatch_set = 1'b1;
    end

    for (int j = 0; j < N_LINES; j++) begin
      n_arr[j] = '0;
      for (int i = 0; i < N_PORTS; i++) begin
        if (gnt[i] && (map_line[i] == LW'(j))) n_arr[j] = n_arr[j] + CW1'(1);
      end
      line_tgt[j] = valid_q[j] ? tgt_q[j] : tgt_eff[alloc_ldr[j]];
      new_cnt[j]  = (valid_q[j] ? {1'b0, cnt_q[j]} : '0) + n_arr[j];
      complete[j] = (n_arr[j] != '0) && (new_cnt[j] >= {1'b0, line_tgt[j]});
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int j = 0; j < N_LINES; j++) begin
        valid_q[j] <= 1'b0;
        sig_q[j]   <= '0;
        cnt_q[j]   <= '0;
        tgt_q[j]   <= '0;
      end
      for (int i = 0; i < N_PORTS; i++) done_q[i] <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      for (int j = 0; j < N_LINES; j++) begin
        if (n_arr[j] != '0) begin
          if (complete[j]) begin
            valid_q[j] <= 1'b0;
            sig_q[j]   <= '0;
            cnt_q[j]   <= '0;
            tgt_q[j]   <= '0;
          end else begin
            valid_q[j] <= 1'b1;
            if (!valid_q[j]) sig_q[j] <= sig_i[alloc_ldr[j]];
            cnt_q[j]   <= new_cnt[j][CNT_WIDTH-1:0];
            tgt_q[j]   <= line_tgt[j];
          end
        end
      end
      for (int i = 0; i < N_PORTS; i++) done_q[i] <= gnt[i] && complete[map_line[i]];
      mismatch_q <= mismatch_q | mismatch_set;
    end
  end

  always_comb begin
    occ = '0;
    for (int j = 0; j < N_LINES; j++) occ = occ + OW'(valid_q[j]);
    for (int i = 0; i < N_PORTS; i++) begin
      gnt_o[i]  = gnt[i];
      done_o[i] = done_q[i];
    end
  end

  assign occupancy_o = occ;
  assign full_o      = (occ == OW'(N_LINES));
  assign mismatch_o  = mismatch_q;

endmodule
